// File: rtl/skeleton_test_if.sv
// skeleton_test_if: test-port bundle for register-file access and pipeline freeze
interface skeleton_test_if;
    logic        test;
    logic        t_ctrl_writeEnable;
    logic [4:0]  t_ctrl_writeReg;
    logic [4:0]  t_ctrl_readRegA;
    logic [4:0]  t_ctrl_readRegB;
    logic [31:0] t_data_writeReg;
    logic [31:0] t_data_readRegA;
    logic [31:0] t_data_readRegB;
    modport master (
        output test, t_ctrl_writeEnable, t_ctrl_writeReg, t_ctrl_readRegA, t_ctrl_readRegB, t_data_writeReg,
        input  t_data_readRegA, t_data_readRegB
    );
    modport slave (
        input  test, t_ctrl_writeEnable, t_ctrl_writeReg, t_ctrl_readRegA, t_ctrl_readRegB, t_data_writeReg,
        output t_data_readRegA, t_data_readRegB
    );
endinterface

// File: rtl/skeleton_test.sv
// skeleton_test: 5-stage F/D/X/M/W core with ROM program, bypassing, load-use stall and test-port freeze
module skeleton_test (
    input  logic            clock,
    input  logic            reset,
    skeleton_test_if.slave  bus
);
    localparam logic [4:0] OP_ADD = 5'd0, OP_ADDI = 5'd5, OP_SW = 5'd7, OP_LW = 5'd8;

    function automatic logic [31:0] rr(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return {op, rd, rs, rt, 12'd0};
    endfunction

    function automatic logic [31:0] ri(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs, input logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic logic writes(input logic [4:0] op);
        return op == OP_ADD || op == OP_ADDI || op == OP_LW;
    endfunction

    function automatic logic [31:0] rom(input logic [4:0] a);
        case (a)
            5'd0:  return ri(OP_ADDI, 5'd1, 5'd0, 17'd10);
            5'd1:  return ri(OP_ADDI, 5'd2, 5'd0, 17'd20);
            5'd2:  return rr(OP_ADD, 5'd4, 5'd2, 5'd1);
            5'd3:  return ri(OP_ADDI, 5'd5, 5'd0, 17'd11);
            5'd4:  return rr(OP_ADD, 5'd6, 5'd1, 5'd5);
            5'd5:  return ri(OP_ADDI, 5'd7, 5'd0, 17'd45);
            5'd7:  return rr(OP_ADD, 5'd8, 5'd7, 5'd1);
            5'd8:  return ri(OP_ADDI, 5'd9, 5'd0, 17'd11);
            5'd10: return rr(OP_ADD, 5'd10, 5'd1, 5'd9);
            5'd11: return ri(OP_ADDI, 5'd11, 5'd0, 17'd8);
            5'd12: return ri(OP_SW, 5'd11, 5'd0, 17'd0);
            5'd13: return ri(OP_LW, 5'd12, 5'd0, 17'd0);
            5'd14: return ri(OP_ADDI, 5'd3, 5'd0, 17'd5);
            5'd15: return ri(OP_LW, 5'd13, 5'd0, 17'd0);
            5'd16: return rr(OP_ADD, 5'd14, 5'd13, 5'd3);
            5'd17: return ri(OP_LW, 5'd15, 5'd0, 17'd0);
            5'd18: return rr(OP_ADD, 5'd16, 5'd3, 5'd15);
            5'd19: return ri(OP_ADDI, 5'd17, 5'd0, 17'd100);
            5'd20: return ri(OP_ADDI, 5'd17, 5'd0, 17'd202);
            5'd21: return rr(OP_ADD, 5'd18, 5'd17, 5'd0);
            5'd22: return ri(OP_ADDI, 5'd19, 5'd0, 17'd7);
            5'd23: return ri(OP_ADDI, 5'd19, 5'd0, 17'd409);
            5'd24: return rr(OP_ADD, 5'd20, 5'd0, 5'd19);
            default: return 32'd0;
        endcase
    endfunction

    logic [4:0]  pc;
    logic [31:0] fd_ir, dx_ir, dx_a, dx_b, xm_o, xm_b, mw_o;
    logic [4:0]  xm_op, xm_rd, mw_op, mw_rd;
    logic [31:0] regs [32];
    logic [31:0] dmem [32];
    logic [4:0]  d_op, d_rs, d_rb, x_op, x_rs, x_rb;
    logic        stall, m_wr, w_wr, d_uses_rs, d_uses_rt;
    logic [31:0] d_a, d_b, x_a, x_b, x_o, m_sd, m_o;

    always_comb begin
        d_op      = fd_ir[31:27];
        d_rs      = fd_ir[21:17];
        d_rb      = d_op == OP_SW ? fd_ir[26:22] : fd_ir[16:12];
        d_uses_rs = writes(d_op) || d_op == OP_SW;
        d_uses_rt = d_op == OP_ADD;
        x_op      = dx_ir[31:27];
        x_rs      = dx_ir[21:17];
        x_rb      = x_op == OP_SW ? dx_ir[26:22] : dx_ir[16:12];
        m_wr      = writes(xm_op) && xm_rd != 5'd0;
        w_wr      = writes(mw_op) && mw_rd != 5'd0;
        // A load in X cannot forward yet; hold F/D one cycle if D consumes its target
        stall     = x_op == OP_LW && dx_ir[26:22] != 5'd0 &&
                    ((d_uses_rs && d_rs == dx_ir[26:22]) || (d_uses_rt && fd_ir[16:12] == dx_ir[26:22]));
        d_a       = w_wr && mw_rd == d_rs ? mw_o : regs[d_rs];
        d_b       = w_wr && mw_rd == d_rb ? mw_o : regs[d_rb];
        x_a       = m_wr && xm_rd == x_rs ? xm_o : w_wr && mw_rd == x_rs ? mw_o : dx_a;
        x_b       = m_wr && xm_rd == x_rb ? xm_o : w_wr && mw_rd == x_rb ? mw_o : dx_b;
        x_o       = x_a + (x_op == OP_ADD ? x_b : {{15{dx_ir[16]}}, dx_ir[16:0]});
        m_sd      = w_wr && mw_rd == xm_rd ? mw_o : xm_b;
        m_o       = xm_op == OP_LW ? dmem[xm_o[4:0]] : xm_o;
    end

    assign bus.t_data_readRegA = regs[bus.t_ctrl_readRegA];
    assign bus.t_data_readRegB = regs[bus.t_ctrl_readRegB];

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc    <= 5'd0;
            fd_ir <= 32'd0;
            dx_ir <= 32'd0;
            dx_a  <= 32'd0;
            dx_b  <= 32'd0;
            xm_op <= 5'd0;
            xm_rd <= 5'd0;
            xm_o  <= 32'd0;
            xm_b  <= 32'd0;
            mw_op <= 5'd0;
            mw_rd <= 5'd0;
            mw_o  <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
                dmem[i] <= 32'd0;
            end
        end else if (bus.test) begin
            if (bus.t_ctrl_writeEnable && bus.t_ctrl_writeReg != 5'd0)
                regs[bus.t_ctrl_writeReg] <= bus.t_data_writeReg;
        end else begin
            if (!stall) begin
                pc    <= &pc ? pc : pc + 5'd1;
                fd_ir <= rom(pc);
            end
            dx_ir <= stall ? 32'd0 : fd_ir;
            dx_a  <= d_a;
            dx_b  <= d_b;
            xm_op <= x_op;
            xm_rd <= dx_ir[26:22];
            xm_o  <= x_o;
            xm_b  <= x_b;
            mw_op <= xm_op;
            mw_rd <= xm_rd;
            mw_o  <= m_o;
            if (xm_op == OP_SW)
                dmem[xm_o[4:0]] <= m_sd;
            if (w_wr)
                regs[mw_rd] <= mw_o;
        end
    end
endmodule

// File: tb/tb_skeleton_test.sv
// tb_skeleton_test: scoreboard bench for skeleton_test; expected register values queued and compared via test ports
module tb_skeleton_test;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    skeleton_test_if bus ();
    skeleton_test dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct {
        string       tag;
        logic        port;
        logic [4:0]  a;
        logic [31:0] v;
    } exp_t;

    exp_t        sb [$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] gold [32];
    localparam logic [31:0] LW13  = {5'd8, 5'd13, 5'd0, 17'd0};
    localparam logic [31:0] ADD14 = {5'd0, 5'd14, 5'd13, 5'd3, 12'd0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic expect_reg(input string tag, input logic [4:0] a, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.a = a;
        e.v = v;
        e.port = 1'b0;
        sb.push_back(e);
        e.port = 1'b1;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.t_ctrl_readRegA = e.port ? ~e.a : e.a;
            bus.t_ctrl_readRegB = e.port ? e.a : ~e.a;
            #1;
            check($sformatf("%s r%0d port %s", e.tag, e.a, e.port ? "B" : "A"),
                  e.port ? bus.t_data_readRegB : bus.t_data_readRegA, e.v);
        end
    endtask

    task automatic expect_program(input string tag);
        for (int i = 0; i < 32; i++) expect_reg(tag, 5'(i), gold[i]);
        drain();
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int t_lw, t_add;
        for (int i = 0; i < 32; i++) gold[i] = 32'd0;
        gold[1] = 10;   gold[2] = 20;   gold[3] = 5;    gold[4] = 30;
        gold[5] = 11;   gold[6] = 21;   gold[7] = 45;   gold[8] = 55;
        gold[9] = 11;   gold[10] = 21;  gold[11] = 8;   gold[12] = 8;
        gold[13] = 8;   gold[14] = 13;  gold[15] = 8;   gold[16] = 13;
        gold[17] = 202; gold[18] = 202; gold[19] = 409; gold[20] = 409;

        // reset must win over a concurrent test-port write
        bus.test = 1'b1;
        bus.t_ctrl_writeEnable = 1'b1;
        bus.t_ctrl_writeReg = 5'd5;
        bus.t_data_writeReg = 32'hffff_ffff;
        bus.t_ctrl_readRegA = 5'd0;
        bus.t_ctrl_readRegB = 5'd0;
        cycles(2);
        for (int i = 0; i < 32; i++) expect_reg("reset", 5'(i), 32'd0);
        drain();
        check("reset pc", 32'(dut.pc), 32'd0);

        // normal run; write enable held high must be ignored outside test mode
        bus.test = 1'b0;
        bus.t_ctrl_writeReg = 5'd25;
        bus.t_data_writeReg = 32'hdead_beef;
        reset = 1'b1;
        t_lw = -1;
        t_add = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clock);
            if (t_lw < 0 && dut.fd_ir == LW13) t_lw = c;
            if (t_add < 0 && dut.dx_ir == ADD14) t_add = c;
            if (c == 40) begin
                expect_reg("by cycle 40", 5'd20, 32'd409);
                expect_reg("by cycle 40", 5'd16, 32'd13);
                drain();
            end
        end
        check("lw r13 in D to add r14 in X", 32'(t_add - t_lw), 32'd3);
        check("lw r13 seen in D", 32'(t_lw > 0), 32'd1);
        bus.t_ctrl_writeEnable = 1'b0;
        bus.test = 1'b1;
        cycles(1);
        expect_program("run1");
        check("pc saturated", 32'(dut.pc), 32'd31);

        // test-port writes: r7 takes the value, r0 stays zero
        bus.t_ctrl_writeEnable = 1'b1;
        bus.t_ctrl_writeReg = 5'd7;
        bus.t_data_writeReg = 32'h1234_5678;
        cycles(1);
        bus.t_ctrl_writeReg = 5'd0;
        cycles(1);
        bus.t_ctrl_writeEnable = 1'b0;
        expect_reg("tport", 5'd7, 32'h1234_5678);
        expect_reg("tport", 5'd0, 32'd0);
        drain();
        cycles(10);
        check("pc held in test", 32'(dut.pc), 32'd31);

        // freeze five cycles into a fresh run, then resume
        reset = 1'b0;
        cycles(2);
        bus.test = 1'b0;
        reset = 1'b1;
        cycles(5);
        bus.test = 1'b1;
        check("freeze pc", 32'(dut.pc), 32'd5);
        expect_reg("frozen", 5'd1, 32'd10);
        expect_reg("frozen", 5'd2, 32'd0);
        drain();
        cycles(10);
        check("freeze pc after 10", 32'(dut.pc), 32'd5);
        expect_reg("frozen after 10", 5'd2, 32'd0);
        drain();
        bus.test = 1'b0;
        cycles(100);
        bus.test = 1'b1;
        cycles(1);
        expect_program("resumed");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
